// File: rtl/result_tx_framer.sv
// Serialises finished lane results as 5-byte frames (SOF, SEQ, CENTER, CONF, CHK)
// on a valid/ready byte stream, with one pending slot and overrun accounting.
module result_tx_framer #(
    parameter logic [7:0] SOF_BYTE = 8'hA5,
    parameter int         DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_signal,
    input  logic [DATA_W-1:0] center,
    input  logic [DATA_W-1:0] confidence,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        overrun_cnt,
    input  logic              overrun_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_SEQ,
        S_CTR,
        S_CONF,
        S_CHK
    } state_t;

    state_t            r_state,     w_state;
    logic [7:0]        r_seq,       w_seq;
    logic [7:0]        r_actSeq,    w_actSeq;
    logic [DATA_W-1:0] r_actCtr,    w_actCtr;
    logic [DATA_W-1:0] r_actConf,   w_actConf;
    logic              r_pendValid, w_pendValid;
    logic [DATA_W-1:0] r_pendCtr,   w_pendCtr;
    logic [DATA_W-1:0] r_pendConf,  w_pendConf;
    logic [DATA_W-1:0] r_txData,    w_txData;
    logic              r_txValid,   w_txValid;
    logic              r_overrun,   w_overrun;
    logic [7:0]        r_ovCnt,     w_ovCnt;

    logic              w_accept;
    logic              w_load;
    logic              w_doneTaken;
    logic              w_promote;
    logic              w_drop;
    logic [DATA_W-1:0] w_loadCtr;
    logic [DATA_W-1:0] w_loadConf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_seq       <= '0;
            r_actSeq    <= '0;
            r_actCtr    <= '0;
            r_actConf   <= '0;
            r_pendValid <= 1'b0;
            r_pendCtr   <= '0;
            r_pendConf  <= '0;
            r_txData    <= '0;
            r_txValid   <= 1'b0;
            r_overrun   <= 1'b0;
            r_ovCnt     <= '0;
        end else begin
            r_state     <= w_state;
            r_seq       <= w_seq;
            r_actSeq    <= w_actSeq;
            r_actCtr    <= w_actCtr;
            r_actConf   <= w_actConf;
            r_pendValid <= w_pendValid;
            r_pendCtr   <= w_pendCtr;
            r_pendConf  <= w_pendConf;
            r_txData    <= w_txData;
            r_txValid   <= w_txValid;
            r_overrun   <= w_overrun;
            r_ovCnt     <= w_ovCnt;
        end
    end

    // tx_data is computed one byte ahead so that both stream outputs come straight from flops.
    always_comb begin
        w_state     = r_state;
        w_seq       = r_seq;
        w_actSeq    = r_actSeq;
        w_actCtr    = r_actCtr;
        w_actConf   = r_actConf;
        w_pendValid = r_pendValid;
        w_pendCtr   = r_pendCtr;
        w_pendConf  = r_pendConf;
        w_txData    = r_txData;
        w_txValid   = r_txValid;
        w_overrun   = r_overrun;
        w_ovCnt     = r_ovCnt;
        w_accept    = r_txValid && tx_ready;
        w_load      = 1'b0;
        w_doneTaken = 1'b0;
        w_promote   = 1'b0;
        w_drop      = 1'b0;
        w_loadCtr   = center;
        w_loadConf  = confidence;

        case (r_state)
            S_IDLE: begin
                if (done_signal) begin
                    w_load      = 1'b1;
                    w_doneTaken = 1'b1;
                end
            end
            S_SOF: begin
                if (w_accept) begin
                    w_state  = S_SEQ;
                    w_txData = r_actSeq;
                end
            end
            S_SEQ: begin
                if (w_accept) begin
                    w_state  = S_CTR;
                    w_txData = r_actCtr;
                end
            end
            S_CTR: begin
                if (w_accept) begin
                    w_state  = S_CONF;
                    w_txData = r_actConf;
                end
            end
            S_CONF: begin
                if (w_accept) begin
                    w_state  = S_CHK;
                    w_txData = r_actSeq ^ r_actCtr ^ r_actConf;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    if (r_pendValid) begin
                        w_load      = 1'b1;
                        w_promote   = 1'b1;
                        w_loadCtr   = r_pendCtr;
                        w_loadConf  = r_pendConf;
                        w_pendValid = 1'b0;
                    end else if (done_signal) begin
                        w_load      = 1'b1;
                        w_doneTaken = 1'b1;
                    end else begin
                        w_state   = S_IDLE;
                        w_txValid = 1'b0;
                        w_txData  = '0;
                    end
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_txValid = 1'b0;
                w_txData  = '0;
            end
        endcase

        // SEQ is only consumed when a result reaches the active registers.
        if (w_load) begin
            w_actSeq  = r_seq;
            w_actCtr  = w_loadCtr;
            w_actConf = w_loadConf;
            w_seq     = r_seq + 8'd1;
            w_state   = S_SOF;
            w_txValid = 1'b1;
            w_txData  = SOF_BYTE;
        end

        if (done_signal && !w_doneTaken) begin
            if (!r_pendValid || w_promote) begin
                w_pendValid = 1'b1;
                w_pendCtr   = center;
                w_pendConf  = confidence;
            end else begin
                w_drop = 1'b1;
            end
        end

        if (w_drop) begin
            w_overrun = 1'b1;
            if (overrun_clr)
                w_ovCnt = 8'd1;
            else if (r_ovCnt != 8'hFF)
                w_ovCnt = r_ovCnt + 8'd1;
        end else if (overrun_clr) begin
            w_overrun = 1'b0;
            w_ovCnt   = '0;
        end
    end

    assign tx_data     = r_txData;
    assign tx_valid    = r_txValid;
    assign busy        = (r_state != S_IDLE) || r_pendValid;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_ovCnt;

endmodule

// File: tb/tb_result_tx_framer.sv
// Scoreboard bench for result_tx_framer: expected frame bytes are queued when a
// result is issued and compared as each byte is accepted on the stream.
module tb_result_tx_framer;

    logic       clk;
    logic       rst;
    logic       done_signal;
    logic [7:0] center;
    logic [7:0] confidence;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       overrun;
    logic [7:0] overrun_cnt;
    logic       overrun_clr;

    int         errors;
    int         checks;
    logic [7:0] expSeq;
    logic [7:0] expQ[$];
    logic [7:0] monByte;
    int         cycles;

    result_tx_framer #(
        .SOF_BYTE(8'hA5),
        .DATA_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .done_signal(done_signal),
        .center     (center),
        .confidence (confidence),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .overrun    (overrun),
        .overrun_cnt(overrun_cnt),
        .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushFrame(input logic [7:0] c, input logic [7:0] f);
        expQ.push_back(8'hA5);
        expQ.push_back(expSeq);
        expQ.push_back(c);
        expQ.push_back(f);
        expQ.push_back(expSeq ^ c ^ f);
        expSeq = expSeq + 8'd1;
    endtask

    // Pulse done for one cycle; results that should reach the wire are queued.
    task automatic applyStimulus(input logic [7:0] c, input logic [7:0] f, input bit willSend);
        center      = c;
        confidence  = f;
        done_signal = 1'b1;
        if (willSend)
            pushFrame(c, f);
        tick();
        done_signal = 1'b0;
    endtask

    task automatic drainWait(input int budget, output int n);
        n = 0;
        while (!(expQ.size() == 0 && !tx_valid) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drainDone", {15'd0, (expQ.size() == 0 && !tx_valid)}, 16'd1);
        checkOutput("busyAfterDrain", {15'd0, busy}, 16'd0);
    endtask

    task automatic hardReset();
        #2;
        rst = 1'b0;
        #1;
        expQ.delete();
        expSeq = 8'h00;
        tick();
        #3;
        rst = 1'b1;
        tick();
    endtask

    // Every accepted byte is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && tx_valid && tx_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("extraByte", {8'h00, tx_data}, 16'hDEAD);
            end else begin
                monByte = expQ.pop_front();
                checkOutput("txByte", {8'h00, tx_data}, {8'h00, monByte});
            end
        end
    end

    initial begin
        errors      = 0;
        checks      = 0;
        expSeq      = 8'h00;
        rst         = 1'b0;
        done_signal = 1'b0;
        center      = '0;
        confidence  = '0;
        tx_ready    = 1'b1;
        overrun_clr = 1'b0;

        #12;
        checkOutput("rstTxData", {8'h00, tx_data}, 16'h0000);
        checkOutput("rstTxValid", {15'd0, tx_valid}, 16'd0);
        checkOutput("rstBusy", {15'd0, busy}, 16'd0);
        checkOutput("rstOverrun", {15'd0, overrun}, 16'd0);
        checkOutput("rstOvCnt", {8'h00, overrun_cnt}, 16'h0000);
        rst = 1'b1;
        tick();

        // Single frame with one-cycle latency to SOF.
        applyStimulus(8'd15, 8'd200, 1'b1);
        checkOutput("sofValid", {15'd0, tx_valid}, 16'd1);
        checkOutput("sofData", {8'h00, tx_data}, 16'h00A5);
        drainWait(20, cycles);
        checkOutput("singleCycles", 16'(cycles), 16'd5);

        // Backpressure on the SEQ byte.
        applyStimulus(8'd15, 8'd200, 1'b1);
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bpValid", {15'd0, tx_valid}, 16'd1);
            checkOutput("bpData", {8'h00, tx_data}, {8'h00, expSeq - 8'd1});
            tick();
        end
        tx_ready = 1'b1;
        drainWait(20, cycles);

        // Back-to-back frames with no idle cycle between them.
        applyStimulus(8'd15, 8'd200, 1'b1);
        applyStimulus(8'd13, 8'd100, 1'b1);
        drainWait(30, cycles);
        checkOutput("b2bCycles", 16'(cycles), 16'd9);

        // Overrun: third result while active and pending are both occupied.
        tx_ready = 1'b0;
        applyStimulus(8'd15, 8'd200, 1'b1);
        applyStimulus(8'd13, 8'd100, 1'b1);
        applyStimulus(8'd9, 8'd50, 1'b0);
        checkOutput("ovFlag", {15'd0, overrun}, 16'd1);
        checkOutput("ovCnt", {8'h00, overrun_cnt}, 16'd1);
        checkOutput("ovBusy", {15'd0, busy}, 16'd1);
        tx_ready = 1'b1;
        drainWait(30, cycles);
        checkOutput("ovSticky", {15'd0, overrun}, 16'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checkOutput("clrFlag", {15'd0, overrun}, 16'd0);
        checkOutput("clrCnt", {8'h00, overrun_cnt}, 16'd0);

        // Counter saturation, then a drop coinciding with a clear.
        tx_ready = 1'b0;
        applyStimulus(8'd1, 8'd2, 1'b1);
        applyStimulus(8'd3, 8'd4, 1'b1);
        for (int i = 0; i < 260; i++)
            applyStimulus(8'(i), 8'(i + 7), 1'b0);
        checkOutput("satCnt", {8'h00, overrun_cnt}, 16'h00FF);
        center      = 8'd5;
        confidence  = 8'd6;
        done_signal = 1'b1;
        overrun_clr = 1'b1;
        tick();
        done_signal = 1'b0;
        overrun_clr = 1'b0;
        checkOutput("dropWinsFlag", {15'd0, overrun}, 16'd1);
        checkOutput("dropWinsCnt", {8'h00, overrun_cnt}, 16'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        tx_ready = 1'b1;
        drainWait(30, cycles);
        checkOutput("clr2Cnt", {8'h00, overrun_cnt}, 16'd0);

        // Reset asserted while the CTR byte is on the wire.
        applyStimulus(8'd15, 8'd200, 1'b1);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRstValid", {15'd0, tx_valid}, 16'd0);
        checkOutput("midRstBusy", {15'd0, busy}, 16'd0);
        checkOutput("midRstData", {8'h00, tx_data}, 16'h0000);
        expQ.delete();
        expSeq = 8'h00;
        tick();
        #3;
        rst = 1'b1;
        tick();
        applyStimulus(8'd15, 8'd200, 1'b1);
        drainWait(20, cycles);

        // SEQ wrap: frame 256 carries FF, frame 257 carries 00.
        hardReset();
        for (int i = 0; i < 257; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            drainWait(12, cycles);
        end
        checkOutput("wrapSeq", {8'h00, expSeq}, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/result_tx_framer.md
Name: result_tx_framer

Overview:
- Transmit-side counterpart of the lane controller's byte receive path.
- Captures each finished result (lane centre + confidence) on `done_signal` and serialises it as a 5-byte framed packet on a byte stream with a valid/ready handshake.
- Sits between `top_controller` outputs and the host link.
- Provides one pending-result slot so back-to-back results are not lost, plus overrun accounting.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker (byte 0 of every frame).
- DATA_W, 8, width of centre, confidence and stream bytes; only 8 is supported.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0), one clock, no other resets.
- done_signal  in  1  single-cycle pulse: centre/conf valid this cycle.
- center  in  DATA_W  lane centre result, sampled when done_signal=1.
- confidence  in  DATA_W  confidence value, sampled when done_signal=1.
- tx_data  out  DATA_W  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid&&tx_ready.
- busy  out  1  frame in progress or pending slot occupied.
- overrun  out  1  sticky: at least one result dropped.
- overrun_cnt  out  8  saturating count of dropped results.
- overrun_clr  in  1  clears overrun and overrun_cnt (synchronous).

Behaviour:
- Reset values: tx_data=0, tx_valid=0, busy=0, overrun=0, overrun_cnt=0, seq=0, pending slot empty, state IDLE.
- Frame format, in order:
  - SOF = SOF_BYTE
  - SEQ
  - CENTER
  - CONF
  - CHK = SEQ ^ CENTER ^ CONF
- FSM states: IDLE, SOF, SEQ, CTR, CONF, CHK. A byte advances only on tx_valid&&tx_ready.
- IDLE with done_signal=1:
  - Latch center/confidence/seq into the active frame registers.
  - Next cycle: tx_valid=1 and tx_data=SOF_BYTE (latency 1 clock).
- Data stability: while tx_valid=1 and tx_ready=0, tx_data and state hold. tx_valid never drops mid-frame.
- SEQ numbering: 8-bit, increments by 1 when a frame is latched into the active registers. Wraps 8'hFF->8'h00. Dropped results do not consume a SEQ.
- done_signal while a frame is active:
  - Pending slot empty: store in the pending slot; its SEQ is assigned when it is promoted.
  - Pending slot full: drop the result, set overrun=1, overrun_cnt+=1 (saturates at 255).
- CHK accepted, pending slot full: promote pending to active. The next cycle is the SOF of the new frame, with tx_valid staying 1 (no gap).
- CHK accepted, pending slot empty, done_signal=1 in the same cycle: the new result goes directly to active, and the next cycle is SOF.
- CHK accepted, pending slot full, done_signal=1 in the same cycle: pending is promoted and the new result is stored into the now-free slot. No drop.
- CHK accepted with no pending and no done: IDLE next cycle, tx_valid=0.
- busy: 1 when state≠IDLE or the pending slot is occupied.
- overrun_clr=1: next cycle overrun=0 and overrun_cnt=0. If a drop happens in the same cycle, the drop wins: overrun=1, overrun_cnt=1.
- Reset mid-frame: frame is abandoned immediately and asynchronously, with no partial completion; all outputs go to their reset values, and seq restarts at 0.
- No combinational path from tx_ready to tx_valid. tx_data and tx_valid are registered.

Test Plan:
- Single frame: done with center=15, confidence=200, tx_ready=1 -> bytes A5,00,0F,C8,C7 on 5 consecutive cycles starting 1 clock after done; then tx_valid=0 and busy=0.
- Backpressure: tx_ready held 0 for 3 cycles while the SEQ byte is presented -> tx_data stays 8'h00 with tx_valid=1; the frame completes unchanged afterward.
- Back-to-back: done(15,200), then done(13,100) during frame 0 -> A5,00,0F,C8,C7 immediately followed by A5,01,0D,64,68 with no idle cycle.
- Overrun: tx_ready=0, three dones (15,200),(13,100),(9,50) -> frames seq 0 and seq 1 only; (9,50) lost; overrun=1, overrun_cnt=1; overrun_clr -> both 0.
- Seq wrap: 257 frames -> frame 256 has SEQ=FF, frame 257 has SEQ=00 and CHK=CENTER^CONF.
- Reset mid-frame: assert rst=0 during the CTR byte -> tx_valid=0 at once; after release, the next done produces SEQ=00.
